// File: rtl/spi_flash_xip.sv
// Read-only APB execute-in-place window over SPI NOR flash (mode 0, cmd 0x03) with a one-line prefetch buffer.
// Hits and errors answer in the access cycle; a miss holds pready low for 2*DIV_HALF*(32+32*LINE_WORDS)+2 cycles.
`ifndef P_ADDR_W
`define P_ADDR_W 32
`endif
`ifndef P_DATA_W
`define P_DATA_W 32
`endif
`ifndef P_STRB_W
`define P_STRB_W 4
`endif

module spi_flash_xip #(
   parameter logic [31:0] FLASH_BASE = 32'h30000000,
   parameter int CS_NUM     = 2,
   parameter int LINE_WORDS = 4,
   parameter int DIV_HALF   = 1,
   parameter int TCSH       = 2
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic [`P_ADDR_W-1:0] in_paddr,
   input  logic                 in_psel,
   input  logic                 in_penable,
   input  logic [2:0]           in_pprot,
   input  logic                 in_pwrite,
   input  logic [`P_DATA_W-1:0] in_pwdata,
   input  logic [`P_STRB_W-1:0] in_pstrb,
   output logic                 in_pready,
   output logic [`P_DATA_W-1:0] in_prdata,
   output logic                 in_pslverr,
   input  logic                 flush,
   output logic                 spi_clk,
   output logic [CS_NUM-1:0]    spi_cs,
   output logic                 spi_mosi,
   input  logic                 spi_miso
);
   localparam int CS_W  = (CS_NUM > 1) ? $clog2(CS_NUM) : 1;
   localparam int LB    = $clog2(LINE_WORDS * 4);
   localparam int WS_W  = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
   localparam int TAG_W = CS_W + 24 - LB;
   localparam int NBITS = 32 + 32 * LINE_WORDS;
   localparam int RX_W  = 32 * LINE_WORDS;
   localparam int BC_W  = $clog2(NBITS);
   localparam int DC_W  = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;
   localparam int HC_W  = $clog2(TCSH + 2);
   localparam logic [31:0]     WIN_SIZE = 32'(CS_NUM) << 24;
   localparam logic [WS_W-1:0] WS_MASK  = WS_W'(LINE_WORDS - 1);

   typedef enum logic [1:0] {IDLE, CSGAP, SHIFT, FILL} state_t;
   state_t state, state_n;

   logic [31:0]                  off;
   logic [TAG_W-1:0]             cur_tag, req_tag, buf_tag, start_tag;
   logic [CS_W-1:0]              start_cs;
   logic [23:0]                  start_addr;
   logic [WS_W-1:0]              wsel;
   logic                         access, err, hit, miss, start, gap_ok, shift_done;
   logic                         valid, resp_pend, flush_pend, sclk_q, hi;
   logic [CS_NUM-1:0]            cs_q;
   logic [31:0]                  tx_q;
   logic [RX_W-1:0]              rx_q;
   logic [DC_W-1:0]              cnt;
   logic [BC_W-1:0]              bitc;
   logic [HC_W-1:0]              hc;
   logic [LINE_WORDS-1:0][31:0]  line_buf, line_data;
   logic                         unused_ok;

   assign unused_ok = ^{in_pprot, in_pwdata, in_pstrb};

   assign off       = in_paddr - FLASH_BASE;
   assign cur_tag   = {off[24 +: CS_W], off[23:LB]};
   assign wsel      = off[2 +: WS_W] & WS_MASK;
   assign access    = in_psel && in_penable;
   assign err       = in_pwrite || (off >= WIN_SIZE);
   assign hit       = valid && (buf_tag == cur_tag);
   assign gap_ok    = (int'(hc) + 1 >= TCSH);
   assign start_tag = (state == IDLE) ? cur_tag : req_tag;
   assign start_cs  = start_tag[TAG_W-1 -: CS_W];
   assign start_addr = {start_tag[23-LB:0], {LB{1'b0}}};
   assign shift_done = (state == SHIFT) && (cnt == DC_W'(DIV_HALF - 1)) && hi
                       && (bitc == BC_W'(NBITS - 1));

   assign spi_clk  = sclk_q;
   assign spi_cs   = cs_q;
   assign spi_mosi = tx_q[31];

   // First received byte of each word lands in bits [7:0].
   always_comb begin
      line_data = '0;
      for (int w = 0; w < LINE_WORDS; w++)
         for (int b = 0; b < 4; b++)
            line_data[w][8*b +: 8] = rx_q[RX_W-1-8*(4*w+b) -: 8];
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_n;
   end

   always_comb begin
      state_n    = state;
      in_pready  = 1'b0;
      in_pslverr = 1'b0;
      in_prdata  = '0;
      miss       = 1'b0;
      start      = 1'b0;
      case (state)
         IDLE: begin
            if (resp_pend) begin
               in_pready = 1'b1;
               in_prdata = line_buf[wsel];
            end else if (access) begin
               if (err) begin
                  in_pready  = 1'b1;
                  in_pslverr = 1'b1;
               end else if (hit) begin
                  in_pready = 1'b1;
                  in_prdata = line_buf[wsel];
               end else begin
                  miss = 1'b1;
                  if (gap_ok) begin
                     start   = 1'b1;
                     state_n = SHIFT;
                  end else begin
                     state_n = CSGAP;
                  end
               end
            end
         end
         CSGAP: begin
            if (gap_ok) begin
               start   = 1'b1;
               state_n = SHIFT;
            end
         end
         SHIFT:   if (shift_done) state_n = FILL;
         FILL:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cs_q       <= '1;
         sclk_q     <= 1'b0;
         tx_q       <= '0;
         rx_q       <= '0;
         cnt        <= '0;
         hi         <= 1'b0;
         bitc       <= '0;
         valid      <= 1'b0;
         buf_tag    <= '0;
         req_tag    <= '0;
         resp_pend  <= 1'b0;
         flush_pend <= 1'b0;
         hc         <= HC_W'(TCSH);
      end else begin
         if (miss) begin
            req_tag    <= cur_tag;
            flush_pend <= 1'b0;
         end else if (flush && state != IDLE) begin
            flush_pend <= 1'b1;
         end
         resp_pend <= (state == FILL);
         // A flush seen at any point during the fetch keeps the new line invalid.
         if (state == FILL) begin
            valid   <= !(flush_pend || flush);
            buf_tag <= req_tag;
         end else if (flush) begin
            valid <= 1'b0;
         end
         if (start) begin
            cs_q   <= ~(CS_NUM'(1) << start_cs);
            sclk_q <= 1'b0;
            tx_q   <= {8'h03, start_addr};
            cnt    <= '0;
            hi     <= 1'b0;
            bitc   <= '0;
         end else if (state == SHIFT) begin
            if (cnt == DC_W'(DIV_HALF - 1)) begin
               cnt <= '0;
               if (!hi) begin
                  hi     <= 1'b1;
                  sclk_q <= 1'b1;
                  rx_q   <= {rx_q[RX_W-2:0], spi_miso};
               end else begin
                  hi     <= 1'b0;
                  sclk_q <= 1'b0;
                  tx_q   <= {tx_q[30:0], 1'b0};
                  if (bitc == BC_W'(NBITS - 1)) cs_q <= '1;
                  else                          bitc <= bitc + 1'b1;
               end
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
         if (shift_done)          hc <= '0;
         else if (int'(hc) < TCSH) hc <= hc + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (state == FILL) line_buf <= line_data;
   end
endmodule

// File: tb/tb_spi_flash_xip.sv
// Bench for spi_flash_xip: APB driver, behavioural SPI flash (byte = address low byte) and a queue of expected responses.
module tb_spi_flash_xip;
   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic [31:0] in_paddr = '0;
   logic        in_psel = 1'b0, in_penable = 1'b0, in_pwrite = 1'b0;
   logic [2:0]  in_pprot = '0;
   logic [31:0] in_pwdata = '0;
   logic [3:0]  in_pstrb = '0;
   logic        in_pready, in_pslverr;
   logic [31:0] in_prdata;
   logic        flush = 1'b0;
   logic        spi_clk, spi_mosi;
   logic        spi_miso = 1'b0;
   logic [1:0]  spi_cs;

   spi_flash_xip dut (
      .clk(clk), .resetn(resetn), .in_paddr(in_paddr), .in_psel(in_psel),
      .in_penable(in_penable), .in_pprot(in_pprot), .in_pwrite(in_pwrite),
      .in_pwdata(in_pwdata), .in_pstrb(in_pstrb), .in_pready(in_pready),
      .in_prdata(in_prdata), .in_pslverr(in_pslverr), .flush(flush),
      .spi_clk(spi_clk), .spi_cs(spi_cs), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
   );

   always #5 clk = ~clk;

   int n_cmp = 0, n_bad = 0;

   typedef struct {logic [31:0] data; logic err; int lat;} exp_t;
   exp_t sb[$];

   // Flash model
   wire         cs_any = &spi_cs;
   logic [31:0] hdr_sh = '0;
   logic [7:0]  m_cmd = '0;
   logic [23:0] m_addr = '0;
   logic [1:0]  m_cs = 2'b11;
   int          kb = 0, m_rises = 0, xfers = 0;
   int          hi_run = 1000, lo_run = 0, last_gap = 0, last_lo = 0;

   function automatic logic miso_bit(input int k, input logic [23:0] a);
      logic [7:0] b;
      if (k < 32) return 1'b0;
      b = a[7:0] + 8'((k - 32) / 8);
      return b[7 - ((k - 32) % 8)];
   endfunction

   function automatic logic [31:0] exp_word(input logic [31:0] addr);
      logic [7:0] a;
      a = {addr[7:2], 2'b00};
      return {a + 8'd3, a + 8'd2, a + 8'd1, a};
   endfunction

   always @(negedge cs_any) begin
      kb = 0; m_rises = 0; xfers++; m_cs = spi_cs; spi_miso = 1'b0;
   end

   always @(posedge spi_clk) begin
      if (!cs_any) begin
         if (kb < 32) hdr_sh = {hdr_sh[30:0], spi_mosi};
         if (kb == 31) begin m_cmd = hdr_sh[31:24]; m_addr = hdr_sh[23:0]; end
         kb++; m_rises++;
      end
   end

   always @(negedge spi_clk) if (!cs_any) spi_miso = miso_bit(kb, m_addr);

   always @(negedge clk) begin
      if (cs_any) hi_run++;
      else begin if (hi_run > 0) last_gap = hi_run; hi_run = 0; end
      if (!spi_cs[0]) lo_run++;
      else begin if (lo_run > 0) last_lo = lo_run; lo_run = 0; end
   end

   // One APB transfer; fl_at >= 0 pulses flush in that wait cycle (0 = first access cycle).
   task automatic apb_access(input logic [31:0] addr, input logic wr, input int fl_at,
                             output int lat, output logic [31:0] rdata, output logic err);
      @(posedge clk); #1;
      in_paddr = addr; in_pwrite = wr; in_psel = 1'b1; in_penable = 1'b0;
      @(posedge clk); #1;
      in_penable = 1'b1; flush = (fl_at == 0);
      lat = 0;
      forever begin
         @(negedge clk);
         if (in_pready) break;
         @(posedge clk); #1;
         lat++;
         flush = (fl_at == lat);
         if (lat > 2000) break;
      end
      rdata = in_prdata; err = in_pslverr;
      @(posedge clk); #1;
      in_psel = 1'b0; in_penable = 1'b0; in_pwrite = 1'b0; flush = 1'b0;
   endtask

   task automatic test_reset;
      resetn = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++; if (spi_cs !== 2'b11) begin n_bad++; $display("FAIL reset_cs got %b want 11", spi_cs); end
      n_cmp++; if (spi_clk !== 1'b0) begin n_bad++; $display("FAIL reset_sclk got %b want 0", spi_clk); end
      n_cmp++; if (spi_mosi !== 1'b0) begin n_bad++; $display("FAIL reset_mosi got %b want 0", spi_mosi); end
      n_cmp++; if (in_pready !== 1'b0) begin n_bad++; $display("FAIL reset_pready got %b want 0", in_pready); end
      n_cmp++; if (in_pslverr !== 1'b0) begin n_bad++; $display("FAIL reset_pslverr got %b want 0", in_pslverr); end
      n_cmp++; if (in_prdata !== 32'h0) begin n_bad++; $display("FAIL reset_prdata got %h want 0", in_prdata); end
      @(posedge clk); #1 resetn = 1'b1;
   endtask

   task automatic test_cold_miss;
      exp_t e; int lat; logic [31:0] d; logic er; int x0;
      x0 = xfers;
      sb.push_back('{exp_word(32'h30000004), 1'b0, 322});
      apb_access(32'h30000004, 1'b0, -1, lat, d, er);
      e = sb.pop_front();
      n_cmp++; if (d !== e.data) begin n_bad++; $display("FAIL cold_data got %h want %h", d, e.data); end
      n_cmp++; if (er !== e.err) begin n_bad++; $display("FAIL cold_err got %b want %b", er, e.err); end
      n_cmp++; if (lat !== e.lat) begin n_bad++; $display("FAIL cold_latency got %0d want %0d", lat, e.lat); end
      n_cmp++; if (m_cmd !== 8'h03) begin n_bad++; $display("FAIL cold_cmd got %h want 03", m_cmd); end
      n_cmp++; if (m_addr !== 24'h0) begin n_bad++; $display("FAIL cold_addr got %h want 000000", m_addr); end
      n_cmp++; if (m_cs !== 2'b10) begin n_bad++; $display("FAIL cold_cs got %b want 10", m_cs); end
      n_cmp++; if (m_rises !== 160) begin n_bad++; $display("FAIL cold_sclk_periods got %0d want 160", m_rises); end
      n_cmp++; if (last_lo !== 320) begin n_bad++; $display("FAIL cold_cs_low_cycles got %0d want 320", last_lo); end
      n_cmp++; if (xfers !== x0 + 1) begin n_bad++; $display("FAIL cold_xfers got %0d want %0d", xfers, x0 + 1); end
   endtask

   task automatic test_hits;
      logic [31:0] addrs [3] = '{32'h30000000, 32'h30000008, 32'h3000000C};
      exp_t e; int lat; logic [31:0] d; logic er; int x0;
      x0 = xfers;
      for (int i = 0; i < 3; i++) begin
         sb.push_back('{exp_word(addrs[i]), 1'b0, 0});
         apb_access(addrs[i], 1'b0, -1, lat, d, er);
         e = sb.pop_front();
         n_cmp++; if (d !== e.data) begin n_bad++; $display("FAIL hit_data[%0d] got %h want %h", i, d, e.data); end
         n_cmp++; if (lat !== e.lat) begin n_bad++; $display("FAIL hit_latency[%0d] got %0d want %0d", i, lat, e.lat); end
      end
      n_cmp++; if (xfers !== x0) begin n_bad++; $display("FAIL hit_no_spi got %0d xfers want %0d", xfers, x0); end
   endtask

   task automatic test_back_to_back;
      exp_t e; int lat; logic [31:0] d; logic er;
      sb.push_back('{exp_word(32'h31000010), 1'b0, 322});
      apb_access(32'h31000010, 1'b0, -1, lat, d, er);
      e = sb.pop_front();
      n_cmp++; if (d !== e.data) begin n_bad++; $display("FAIL cs1_data got %h want %h", d, e.data); end
      n_cmp++; if (lat !== e.lat) begin n_bad++; $display("FAIL cs1_latency got %0d want %0d", lat, e.lat); end
      n_cmp++; if (m_cs !== 2'b01) begin n_bad++; $display("FAIL cs1_cs got %b want 01", m_cs); end
      n_cmp++; if (m_addr !== 24'h000010) begin n_bad++; $display("FAIL cs1_addr got %h want 000010", m_addr); end
      sb.push_back('{exp_word(32'h30000020), 1'b0, 322});
      apb_access(32'h30000020, 1'b0, -1, lat, d, er);
      e = sb.pop_front();
      n_cmp++; if (d !== e.data) begin n_bad++; $display("FAIL b2b_data got %h want %h", d, e.data); end
      n_cmp++; if (lat !== e.lat) begin n_bad++; $display("FAIL b2b_latency got %0d want %0d", lat, e.lat); end
      n_cmp++; if (last_gap < 2) begin n_bad++; $display("FAIL b2b_cs_gap got %0d want >=2", last_gap); end
   endtask

   task automatic test_errors;
      logic [31:0] addrs [3] = '{32'h30000000, 32'h32000000, 32'h2FFFFFFC};
      logic        wrs   [3] = '{1'b1, 1'b0, 1'b0};
      exp_t e; int lat; logic [31:0] d; logic er; int x0;
      x0 = xfers;
      for (int i = 0; i < 3; i++) begin
         sb.push_back('{32'h0, 1'b1, 0});
         apb_access(addrs[i], wrs[i], -1, lat, d, er);
         e = sb.pop_front();
         n_cmp++; if (er !== e.err) begin n_bad++; $display("FAIL err_slverr[%0d] got %b want %b", i, er, e.err); end
         n_cmp++; if (d !== e.data) begin n_bad++; $display("FAIL err_prdata[%0d] got %h want %h", i, d, e.data); end
         n_cmp++; if (lat !== e.lat) begin n_bad++; $display("FAIL err_latency[%0d] got %0d want %0d", i, lat, e.lat); end
      end
      n_cmp++; if (spi_cs !== 2'b11) begin n_bad++; $display("FAIL err_cs got %b want 11", spi_cs); end
      n_cmp++; if (xfers !== x0) begin n_bad++; $display("FAIL err_no_spi got %0d xfers want %0d", xfers, x0); end
   endtask

   task automatic test_flush;
      logic [31:0] addrs [5] = '{32'h30000040, 32'h30000044, 32'h30000048, 32'h30000048, 32'h3000004C};
      int          fls   [5] = '{50, -1, 0, -1, -1};
      int          lats  [5] = '{322, 322, 0, 322, 322};
      exp_t e; int lat; logic [31:0] d; logic er;
      for (int i = 0; i < 5; i++) begin
         if (i == 4) begin
            @(posedge clk); #1 flush = 1'b1;
            @(posedge clk); #1 flush = 1'b0;
         end
         sb.push_back('{exp_word(addrs[i]), 1'b0, lats[i]});
         apb_access(addrs[i], 1'b0, fls[i], lat, d, er);
         e = sb.pop_front();
         n_cmp++; if (d !== e.data) begin n_bad++; $display("FAIL flush_data[%0d] got %h want %h", i, d, e.data); end
         n_cmp++; if (lat !== e.lat) begin n_bad++; $display("FAIL flush_latency[%0d] got %0d want %0d", i, lat, e.lat); end
      end
   endtask

   task automatic test_reset_mid;
      exp_t e; int lat; logic [31:0] d; logic er; int x0;
      @(posedge clk); #1;
      in_paddr = 32'h30000080; in_psel = 1'b1; in_penable = 1'b0;
      @(posedge clk); #1 in_penable = 1'b1;
      repeat (100) @(posedge clk);
      @(posedge spi_clk); #3;
      resetn = 1'b0;
      #1;
      n_cmp++; if (spi_cs !== 2'b11) begin n_bad++; $display("FAIL midrst_cs got %b want 11", spi_cs); end
      n_cmp++; if (spi_clk !== 1'b0) begin n_bad++; $display("FAIL midrst_sclk got %b want 0", spi_clk); end
      in_psel = 1'b0; in_penable = 1'b0;
      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;
      x0 = xfers;
      sb.push_back('{exp_word(32'h30000040), 1'b0, 322});
      apb_access(32'h30000040, 1'b0, -1, lat, d, er);
      e = sb.pop_front();
      n_cmp++; if (d !== e.data) begin n_bad++; $display("FAIL midrst_data got %h want %h", d, e.data); end
      n_cmp++; if (lat !== e.lat) begin n_bad++; $display("FAIL midrst_latency got %0d want %0d", lat, e.lat); end
      n_cmp++; if (xfers !== x0 + 1) begin n_bad++; $display("FAIL midrst_refetch got %0d xfers want %0d", xfers, x0 + 1); end
   endtask

   initial begin
      test_reset;
      test_cold_miss;
      test_hits;
      test_back_to_back;
      test_errors;
      test_flush;
      test_reset_mid;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
